// File: rtl/noc_pkt_codec_if.sv
// noc_pkt_codec_if
//   Handshake and data bundle between a user module, the packet codec and
//   the NoC fabric port. Clock and reset are kept out of the bundle.
//   master : the user/fabric side. It drives the codec inputs.
//   slave  : the codec itself.
//   Signals:
//     tx_data_in/tx_dest_in/tx_valid_in/tx_ready_out : payload to be packed
//     tx_packet_out/tx_valid_out/tx_ready_in         : packet toward fabric
//     rx_packet_in/rx_valid_in/rx_ready_out          : packet from fabric
//     rx_data_out/rx_valid_out/rx_ready_in           : unpacked payload
//     rx_error_out                                   : sticky RX format error
interface noc_pkt_codec_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int WIDTH_PKT     = 512,
  parameter int WIDTH_DATA    = 16
);
  logic [WIDTH_DATA-1:0]    tx_data_in;
  logic [ADDRESS_WIDTH-1:0] tx_dest_in;
  logic                     tx_valid_in;
  logic                     tx_ready_out;
  logic [WIDTH_PKT-1:0]     tx_packet_out;
  logic                     tx_valid_out;
  logic                     tx_ready_in;
  logic [WIDTH_PKT-1:0]     rx_packet_in;
  logic                     rx_valid_in;
  logic                     rx_ready_out;
  logic [WIDTH_DATA-1:0]    rx_data_out;
  logic                     rx_valid_out;
  logic                     rx_ready_in;
  logic                     rx_error_out;

  modport master (
    output tx_data_in, tx_dest_in, tx_valid_in, tx_ready_in,
    output rx_packet_in, rx_valid_in, rx_ready_in,
    input  tx_ready_out, tx_packet_out, tx_valid_out,
    input  rx_ready_out, rx_data_out, rx_valid_out, rx_error_out
  );

  modport slave (
    input  tx_data_in, tx_dest_in, tx_valid_in, tx_ready_in,
    input  rx_packet_in, rx_valid_in, rx_ready_in,
    output tx_ready_out, tx_packet_out, tx_valid_out,
    output rx_ready_out, rx_data_out, rx_valid_out, rx_error_out
  );
endinterface

// File: rtl/noc_pkt_codec.sv
// noc_pkt_codec
//   Packs a WIDTH_DATA payload plus destination into a multi-flit NoC packet
//   (TX) and unpacks a received packet back into the payload (RX). Each path
//   is a single registered valid/ready stage, so TX->RX loopback is 2 cycles
//   of latency at 1 word/cycle.
//   Ports:
//     clk  : clock
//     rst  : asynchronous active-high reset
//     bus  : noc_pkt_codec_if.slave, all handshake/data signals
//   Configuration macro:
//     PKT_CODEC_RX_CHECK_EN : when defined, rx_error_out becomes a sticky flag
//       raised on any accepted RX packet whose head flit is malformed or
//       addressed to another node. When undefined, rx_error_out is 0.
//   Flit layout (flit 0 is the most significant flit of the packet):
//     [W-1] valid, [W-2] head, [W-3] tail, then payload.
//     Head flit: flags, VC, dest, HEAD_PL payload bits.
//     Body flit: flags, BODY_PL payload bits.
module noc_pkt_codec #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_NOC        = 128,
  parameter int WIDTH_PKT        = 512,
  parameter int WIDTH_DATA       = 16,
  parameter int NODE_ID          = 1
) (
  input  logic             clk,
  input  logic             rst,
  noc_pkt_codec_if.slave   bus
);

  localparam int NUM_FLITS = WIDTH_PKT / WIDTH_NOC;
  localparam int PKT_REM   = WIDTH_PKT - NUM_FLITS * WIDTH_NOC;
  localparam int HEAD_PL   = WIDTH_NOC - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
  localparam int BODY_PL   = WIDTH_NOC - 3;
  localparam int F         = (WIDTH_DATA <= HEAD_PL) ? 1 :
                             1 + (WIDTH_DATA - HEAD_PL + BODY_PL - 1) / BODY_PL;
  // Payload capacity of the F used flits. It is always >= WIDTH_DATA.
  localparam int EXT       = HEAD_PL + (F - 1) * BODY_PL;

  generate
    if (F > NUM_FLITS) begin : g_bad_cfg
      $error("noc_pkt_codec: WIDTH_DATA needs more flits than WIDTH_PKT holds");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // TX packing
  // ---------------------------------------------------------------------------
  logic [EXT-1:0]       w_tx_ext;
  logic [WIDTH_PKT-1:0] w_tx_pkt;

  assign w_tx_ext = EXT'(bus.tx_data_in);

  generate
    for (genvar k = 0; k < NUM_FLITS; k++) begin : g_pack
      localparam int HI = WIDTH_PKT - 1 - k * WIDTH_NOC;
      if (k == 0) begin : g_head
        assign w_tx_pkt[HI -: WIDTH_NOC] = {1'b1, 1'b1, ((F == 1) ? 1'b1 : 1'b0),
                                            {VC_ADDRESS_WIDTH{1'b0}},
                                            bus.tx_dest_in,
                                            w_tx_ext[HEAD_PL-1:0]};
      end else if (k < F) begin : g_body
        assign w_tx_pkt[HI -: WIDTH_NOC] = {1'b1, 1'b0, ((k == F - 1) ? 1'b1 : 1'b0),
                                            w_tx_ext[HEAD_PL + (k-1)*BODY_PL +: BODY_PL]};
      end else begin : g_idle
        assign w_tx_pkt[HI -: WIDTH_NOC] = '0;
      end
    end
    // Bits below the last whole flit carry nothing.
    if (PKT_REM > 0) begin : g_rem
      assign w_tx_pkt[PKT_REM-1:0] = '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // TX stage
  // ---------------------------------------------------------------------------
  logic                 r_tx_full;
  logic [WIDTH_PKT-1:0] r_tx_pkt;
  logic                 w_tx_load;

  assign bus.tx_ready_out  = !r_tx_full || bus.tx_ready_in;
  assign w_tx_load         = bus.tx_valid_in && bus.tx_ready_out;
  assign bus.tx_valid_out  = r_tx_full;
  assign bus.tx_packet_out = r_tx_pkt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_full <= 1'b0;
      r_tx_pkt  <= '0;
    end else if (w_tx_load) begin
      // Load wins over a simultaneous drain, so full stays set.
      r_tx_full <= 1'b1;
      r_tx_pkt  <= w_tx_pkt;
    end else if (r_tx_full && bus.tx_ready_in) begin
      r_tx_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RX unpacking: gather the payload fields of the used flits back into one
  // contiguous vector. VC/dest are ignored for data.
  // ---------------------------------------------------------------------------
  logic [EXT-1:0]        w_rx_ext;
  logic [WIDTH_DATA-1:0] w_rx_data;

  generate
    for (genvar k = 0; k < F; k++) begin : g_unpack
      localparam int LO = WIDTH_PKT - (k + 1) * WIDTH_NOC;
      if (k == 0) begin : g_head
        assign w_rx_ext[HEAD_PL-1:0] = bus.rx_packet_in[LO +: HEAD_PL];
      end else begin : g_body
        assign w_rx_ext[HEAD_PL + (k-1)*BODY_PL +: BODY_PL] = bus.rx_packet_in[LO +: BODY_PL];
      end
    end
  endgenerate

  assign w_rx_data = w_rx_ext[WIDTH_DATA-1:0];

  // Flags, idle flits and padding above WIDTH_DATA are not needed for data.
  logic w_unused;
  assign w_unused = ^{bus.rx_packet_in, w_rx_ext};

  // ---------------------------------------------------------------------------
  // RX stage
  // ---------------------------------------------------------------------------
  logic                  r_rx_full;
  logic [WIDTH_DATA-1:0] r_rx_data;
  logic                  w_rx_load;

  assign bus.rx_ready_out = !r_rx_full || bus.rx_ready_in;
  assign w_rx_load        = bus.rx_valid_in && bus.rx_ready_out;
  assign bus.rx_valid_out = r_rx_full;
  assign bus.rx_data_out  = r_rx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_full <= 1'b0;
      r_rx_data <= '0;
    end else if (w_rx_load) begin
      r_rx_full <= 1'b1;
      r_rx_data <= w_rx_data;
    end else if (r_rx_full && bus.rx_ready_in) begin
      r_rx_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RX format / destination check
  // ---------------------------------------------------------------------------
`ifdef PKT_CODEC_RX_CHECK_EN
  localparam int DEST_HI  = WIDTH_PKT - 4 - VC_ADDRESS_WIDTH;
  localparam int TAIL_BIT = WIDTH_PKT - 3 - (F - 1) * WIDTH_NOC;

  logic w_rx_bad;
  logic r_rx_err;

  assign w_rx_bad = !bus.rx_packet_in[WIDTH_PKT-1]
                 || !bus.rx_packet_in[WIDTH_PKT-2]
                 || (bus.rx_packet_in[DEST_HI -: ADDRESS_WIDTH] != ADDRESS_WIDTH'(NODE_ID))
                 || !bus.rx_packet_in[TAIL_BIT];

  // Sticky until reset; the payload is still delivered on an error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_err <= 1'b0;
    end else if (w_rx_load && w_rx_bad) begin
      r_rx_err <= 1'b1;
    end
  end

  assign bus.rx_error_out = r_rx_err;
`else
  assign bus.rx_error_out = 1'b0;
`endif

endmodule

// File: tb/tb_noc_pkt_codec.sv
// Directed bench for noc_pkt_codec: reset state, single TX packet layout,
// multi-flit (260-bit) layout and loopback, 1000-word loopback with an RX
// stall, and the RX destination check (expectation follows the macro).
module tb_noc_pkt_codec;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  noc_pkt_codec_if #(.ADDRESS_WIDTH(4), .WIDTH_PKT(512), .WIDTH_DATA(16))  b0();
  noc_pkt_codec_if #(.ADDRESS_WIDTH(4), .WIDTH_PKT(512), .WIDTH_DATA(260)) b1();

  noc_pkt_codec #(.WIDTH_DATA(16))  u0 (.clk(clk), .rst(rst), .bus(b0));
  noc_pkt_codec #(.WIDTH_DATA(260)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // Loopback muxing: lpX=1 ties the DUT's TX output to its own RX input.
  logic           lp0, lp1, rx_vld0, tx_rdy0, tx_rdy1;
  logic [511:0]   rx_pkt0;

  always_comb begin
    b0.rx_packet_in = lp0 ? b0.tx_packet_out : rx_pkt0;
    b0.rx_valid_in  = lp0 ? b0.tx_valid_out  : rx_vld0;
    b0.tx_ready_in  = lp0 ? b0.rx_ready_out  : tx_rdy0;
    b1.rx_packet_in = b1.tx_packet_out;
    b1.rx_valid_in  = lp1 && b1.tx_valid_out;
    b1.tx_ready_in  = lp1 ? b1.rx_ready_out  : tx_rdy1;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`ifdef PKT_CODEC_RX_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [511:0] exp_pkt;
  logic [287:0] rnd;
  logic [259:0] d260;
  logic [15:0]  words [1000];
  logic [15:0]  q [$];
  logic [15:0]  prev_d, exp_w;
  logic         prev_v, stall;
  integer       seed;
  int sent, rcvd, cyc, t_in, t_out, t_last;

  initial begin
    rst = 1'b1;
    lp0 = 1'b0; lp1 = 1'b0; rx_vld0 = 1'b0; tx_rdy0 = 1'b0; tx_rdy1 = 1'b0;
    rx_pkt0 = '0;
    b0.tx_data_in = '0; b0.tx_dest_in = '0; b0.tx_valid_in = 1'b0; b0.rx_ready_in = 1'b0;
    b1.tx_data_in = '0; b1.tx_dest_in = '0; b1.tx_valid_in = 1'b0; b1.rx_ready_in = 1'b1;

    // ---- reset state ----
    #12;
    chk("rst_tx_valid", b0.tx_valid_out, 0);
    chk("rst_rx_valid", b0.rx_valid_out, 0);
    chk("rst_tx_pkt",   b0.tx_packet_out, 0);
    chk("rst_rx_data",  b0.rx_data_out, 0);
    chk("rst_err",      b0.rx_error_out, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_tx_ready", b0.tx_ready_out, 1);
    chk("rst_rx_ready", b0.rx_ready_out, 1);

    // ---- single TX word, held by downstream ----
    b0.tx_data_in = 16'hF00D; b0.tx_dest_in = 4'd1; b0.tx_valid_in = 1'b1;
    @(negedge clk); b0.tx_valid_in = 1'b0; #1;
    exp_pkt = {3'b111, 1'b0, 4'b0001, 104'b0, 16'hF00D, 384'b0};
    chk("tx1_valid", b0.tx_valid_out, 1);
    chk("tx1_pkt",   b0.tx_packet_out, exp_pkt);
    chk("tx1_ready_full", b0.tx_ready_out, 0);
    @(negedge clk); #1;
    chk("tx1_hold_pkt",   b0.tx_packet_out, exp_pkt);
    chk("tx1_hold_valid", b0.tx_valid_out, 1);
    tx_rdy0 = 1'b1;
    @(negedge clk); #1;
    chk("tx1_drained", b0.tx_valid_out, 0);
    tx_rdy0 = 1'b0;

    // ---- multi-flit, 260-bit payload: F = 3 ----
    rnd  = {$urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
    d260 = rnd[259:0];
    b1.tx_data_in = d260; b1.tx_dest_in = 4'h5; b1.tx_valid_in = 1'b1;
    @(negedge clk); b1.tx_valid_in = 1'b0; #1;
    exp_pkt = {3'b110, 1'b0, 4'h5, d260[119:0],
               3'b100, d260[244:120],
               3'b101, 110'b0, d260[259:245],
               128'b0};
    chk("mf_pkt",      b1.tx_packet_out, exp_pkt);
    chk("mf_tail253",  b1.tx_packet_out[253], 1);
    chk("mf_bit125",   b1.tx_packet_out[125], 0);
    chk("mf_flit3",    b1.tx_packet_out[127:0], 0);
    lp1 = 1'b1;
    @(negedge clk); #1;
    chk("mf_rx_valid", b1.rx_valid_out, 1);
    chk("mf_rx_data",  b1.rx_data_out, d260);

    // ---- RX check: good, bad (dest 3), good ----
    b0.rx_ready_in = 1'b1;
    rx_pkt0 = {3'b111, 1'b0, 4'd1, 104'b0, 16'h1234, 384'b0};
    rx_vld0 = 1'b1;
    @(negedge clk); rx_vld0 = 1'b0; #1;
    chk("rxg_data", b0.rx_data_out, 16'h1234);
    chk("rxg_err",  b0.rx_error_out, 0);
    rx_pkt0 = {3'b111, 1'b0, 4'd3, 104'b0, 16'h5678, 384'b0};
    rx_vld0 = 1'b1;
    @(negedge clk); rx_vld0 = 1'b0; #1;
    chk("rxb_data", b0.rx_data_out, 16'h5678);
    chk("rxb_err",  b0.rx_error_out, EXP_ERR);
    rx_pkt0 = {3'b111, 1'b0, 4'd1, 104'b0, 16'h9ABC, 384'b0};
    rx_vld0 = 1'b1;
    @(negedge clk); rx_vld0 = 1'b0; #1;
    chk("rxg2_data", b0.rx_data_out, 16'h9ABC);
    chk("rxg2_err",  b0.rx_error_out, EXP_ERR);

    // ---- reset mid-transfer: TX holds a word, RX output pending ----
    b0.rx_ready_in = 1'b0;
    b0.tx_data_in = 16'hBEEF; b0.tx_valid_in = 1'b1;
    @(negedge clk); b0.tx_valid_in = 1'b0; #1;
    chk("mid_tx_valid", b0.tx_valid_out, 1);
    rst = 1'b1; #2;
    chk("mid_rst_tx_valid", b0.tx_valid_out, 0);
    chk("mid_rst_tx_pkt",   b0.tx_packet_out, 0);
    chk("mid_rst_rx_valid", b0.rx_valid_out, 0);
    chk("mid_rst_err",      b0.rx_error_out, 0);
    @(negedge clk); rst = 1'b0;

    // ---- 1000-word loopback with 3-cycle RX stall ----
    seed = 32'hBAADF00D;
    for (int i = 0; i < 1000; i++) words[i] = 16'($random(seed));
    lp0 = 1'b1;
    sent = 0; rcvd = 0; cyc = 0; t_in = -1; t_out = -1; t_last = 0;
    prev_d = '0; prev_v = 1'b0;
    while (rcvd < 1000 && cyc < 1200) begin
      @(negedge clk);
      stall = (cyc >= 500 && cyc < 503);
      b0.rx_ready_in = !stall;
      b0.tx_valid_in = (sent < 1000);
      if (sent < 1000) b0.tx_data_in = words[sent];
      #1;
      if (cyc == 500) begin
        prev_d = b0.rx_data_out; prev_v = b0.rx_valid_out;
      end
      if (cyc > 500 && cyc <= 503) begin
        chk("bp_hold_data",  b0.rx_data_out, prev_d);
        chk("bp_hold_valid", b0.rx_valid_out, prev_v);
      end
      if (stall) chk("bp_tx_ready", b0.tx_ready_out, 0);
      if (b0.rx_valid_out && b0.rx_ready_in) begin
        if (t_out < 0) t_out = cyc;
        t_last = cyc;
        if (q.size() == 0) chk("lb_extra_word", 1, 0);
        else begin
          exp_w = q.pop_front();
          chk("lb_data", b0.rx_data_out, exp_w);
        end
        rcvd++;
      end
      if (b0.tx_valid_in && b0.tx_ready_out) begin
        if (t_in < 0) t_in = cyc;
        q.push_back(words[sent]);
        sent++;
      end
      cyc++;
    end
    b0.tx_valid_in = 1'b0;
    chk("lb_count",      rcvd, 1000);
    chk("lb_leftover",   q.size(), 0);
    chk("lb_latency",    t_out - t_in, 2);
    chk("lb_throughput", t_last - t_out, 1002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
